// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: credit-limited in-order word fetch, 2-entry
// instruction buffer toward decode, and squash/restart on an EX redirect.
`timescale 1ns/1ps
module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_ctrl,
   input  logic [31:0] br_dst,
   input  logic        id_stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic [1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]  drop_cnt_q, drop_cnt_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] fifo_pc_q   [2];
   logic [31:0] fifo_inst_q [2];

   logic [2:0]  credit_used;
   logic        req_fire;
   logic        resp_take;
   logic        push;
   logic        pop;

   // Buffered plus in-flight instructions never exceed the two buffer slots.
   assign credit_used    = {1'b0, count_q} + {1'b0, out_cnt_q};
   assign imem_req_valid = !rst && !br_ctrl && (credit_used < 3'd2);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_take = imem_resp_valid && (out_cnt_q != 2'd0);
   assign push      = resp_take && (drop_cnt_q == 2'd0) && !br_ctrl;

   assign if_valid = (count_q != 2'd0) && !br_ctrl;
   assign if_pc    = (count_q != 2'd0) ? fifo_pc_q[rd_ptr_q]   : 32'h0;
   assign if_inst  = (count_q != 2'd0) ? fifo_inst_q[rd_ptr_q] : NOP;
   assign pop      = if_valid && !id_stall;

   always_comb begin
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      out_cnt_d  = out_cnt_q + {1'b0, req_fire} - {1'b0, resp_take};
      drop_cnt_d = drop_cnt_q;
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d   = rd_ptr_q ^ pop;
      wr_ptr_d   = wr_ptr_q ^ push;
      if (req_fire) pc_d = pc_q + 32'd4;
      if (push) rsp_pc_d = rsp_pc_q + 32'd4;
      if (resp_take && (drop_cnt_q != 2'd0)) drop_cnt_d = drop_cnt_q - 2'd1;
      // Every request still outstanding after this cycle's response is stale.
      if (br_ctrl) begin
         pc_d       = br_dst;
         rsp_pc_d   = br_dst;
         drop_cnt_d = out_cnt_q - {1'b0, resp_take};
         count_d    = 2'd0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_cnt_q  <= 2'd0;
         drop_cnt_q <= 2'd0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
         fifo_inst_q[wr_ptr_q] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: in-order memory model with
// programmable latency, and an expected-PC tracker for the decode stream.
`timescale 1ns/1ps
module tb_fetch_redirect_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] XORK   = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        br_ctrl;
   logic [31:0] br_dst;
   logic        id_stall;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data  = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   always #5 clk = ~clk;

   fetch_redirect_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .br_ctrl(br_ctrl), .br_dst(br_dst),
      .id_stall(id_stall), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // In-order memory: accepted in cycle c, answered in cycle c+k_lat.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } txn_t;
   txn_t mq[$];
   int   cyc   = 0;
   int   k_lat = 1;

   always @(posedge clk) begin
      if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + k_lat});
      if (imem_resp_valid && (mq.size() > 0)) void'(mq.pop_front());
      cyc++;
      #1;
      if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mq[0].addr ^ XORK;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
   end

   logic [31:0] exp_pc;
   int          n_out = 0;

   task automatic mon();
      if (!rst && if_valid) begin
         chk("if_pc", if_pc, exp_pc);
         chk("if_inst", if_inst, exp_pc ^ XORK);
         if (!id_stall) begin
            exp_pc = exp_pc + 32'd4;
            n_out++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n0;
      bit found;

      rst = 1'b1; br_ctrl = 1'b0; br_dst = 32'h0; id_stall = 1'b0;
      imem_req_ready = 1'b1; exp_pc = RST_PC;
      repeat (3) step();
      #1;
      chk("rst_ifv", {31'h0, if_valid}, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h13);
      chk("rst_reqv", {31'h0, imem_req_valid}, 32'h0);

      // free run, k=1
      rst = 1'b0;
      #1;
      chk("rel_reqv", {31'h0, imem_req_valid}, 32'h1);
      chk("rel_addr", imem_req_addr, RST_PC);
      lat = 0;
      while (!if_valid && lat < 20) begin
         step();
         lat++;
         #1;
      end
      chk("first_lat", lat, 2);
      repeat (30) step();
      chk("run_cnt", (n_out >= 15) ? 1 : 0, 1);

      // decode stall
      id_stall = 1'b1;
      repeat (5) step();
      #1;
      chk("stall_reqv", {31'h0, imem_req_valid}, 32'h0);
      chk("stall_ifv", {31'h0, if_valid}, 32'h1);
      id_stall = 1'b0;
      n0 = n_out;
      repeat (12) step();
      chk("stall_resume", (n_out >= n0 + 6) ? 1 : 0, 1);

      // redirect with two requests in flight, k=3
      k_lat = 3;
      repeat (8) step();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mq.size() == 2 && !imem_resp_valid) found = 1;
         else step();
      end
      chk("wait_inflight2", {31'h0, found}, 32'h1);
      br_ctrl = 1'b1; br_dst = 32'h100; exp_pc = 32'h100;
      #1;
      chk("redir_reqv", {31'h0, imem_req_valid}, 32'h0);
      chk("redir_ifv", {31'h0, if_valid}, 32'h0);
      step();
      br_ctrl = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (imem_req_valid) found = 1;
         else step();
      end
      chk("redir_first_addr", imem_req_addr, 32'h100);
      n0 = n_out;
      repeat (20) step();
      chk("redir_flow", (n_out >= n0 + 2) ? 1 : 0, 1);

      // redirect in the same cycle as a response
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (imem_resp_valid && mq.size() >= 2) found = 1;
         else step();
      end
      chk("wait_resp", {31'h0, found}, 32'h1);
      br_ctrl = 1'b1; br_dst = 32'h180; exp_pc = 32'h180;
      step();
      br_ctrl = 1'b0;
      n0 = n_out;
      repeat (20) step();
      chk("redir_resp_flow", (n_out >= n0 + 2) ? 1 : 0, 1);

      // back-to-back redirects under stall
      id_stall = 1'b1;
      br_ctrl = 1'b1; br_dst = 32'h200;
      step();
      br_dst = 32'h300; exp_pc = 32'h300;
      step();
      br_ctrl = 1'b0;
      repeat (14) step();
      #1;
      chk("b2b_ifv", {31'h0, if_valid}, 32'h1);
      chk("b2b_pc", if_pc, 32'h300);
      id_stall = 1'b0;
      n0 = n_out;
      repeat (15) step();
      chk("b2b_flow", (n_out >= n0 + 2) ? 1 : 0, 1);

      // reset with two requests in flight; late responses must be ignored
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mq.size() == 2 && !imem_resp_valid) found = 1;
         else step();
      end
      chk("wait_inflight_rst", {31'h0, found}, 32'h1);
      rst = 1'b1; imem_req_ready = 1'b0; exp_pc = RST_PC;
      step();
      rst = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() == 0 && !imem_resp_valid) found = 1;
         else step();
      end
      chk("late_drained", {31'h0, found}, 32'h1);
      #1;
      chk("late_ifv", {31'h0, if_valid}, 32'h0);
      chk("late_addr", imem_req_addr, RST_PC);
      imem_req_ready = 1'b1;
      n0 = n_out;
      repeat (15) step();
      chk("rst_flow", (n_out >= n0 + 2) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
